// File: rtl/strb_ser_pkg.sv
// Shared types for the strobed word serialiser.
// FSM states, error bit indices, buffered word layout and byte-mask helper.
package strb_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVF     = 1;

  typedef struct packed {
    logic [1:0]  strobe;
    logic [31:0] data;
  } word_t;

  // Halfword strobe expanded to one enable per byte.
  function automatic logic [3:0] byte_mask(input logic [1:0] s);
    return {s[1], s[1], s[0], s[0]};
  endfunction

endpackage

// File: rtl/strb_word_fifo.sv
// First-word-fall-through buffer of {strobe,data} words.
// Ports: push/wr_word in, pop/rd_word out, full/empty flags, count 0..DEPTH.
module strb_word_fifo
  import strb_ser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  word_t                  wr_word,
  input  logic                   pop,
  output word_t                  rd_word,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  word_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop & ~empty;
  // A push into a full buffer is legal when a pop frees a slot this cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_word;
  end

  assign rd_word = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/strb_word_serializer.sv
// Buffers strobed 32-bit words and feeds enabled bytes, LSB first, to uart_tx.
// Ports: wr_valid/wr_data/wr_strobe in, busy/level out, tx_dv/tx_byte/tx_done, err/err_clr.
module strb_word_serializer
  import strb_ser_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 2048
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [31:0]            wr_data,
  input  logic [1:0]             wr_strobe,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_dv,
  output logic [7:0]             tx_byte,
  input  logic                   tx_done,
  output logic [1:0]             err,
  input  logic                   err_clr
);

  localparam int TW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(WAIT_MAX);

  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    low;
  logic          dv_d;
  logic [7:0]    byte_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    err_d;
  logic          push, pop, full, empty;
  logic          timeout;
  word_t         head;
  word_t         in_word;

  assign push    = wr_valid & ~full & (wr_strobe != 2'b00);
  assign pop     = (state_q == IDLE) & ~empty;
  assign busy    = full;
  assign in_word = '{strobe: wr_strobe, data: wr_data};

  strb_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_word(in_word),
    .pop    (pop),
    .rd_word(head),
    .full   (full),
    .empty  (empty),
    .count  (level)
  );

  // Isolate the lowest pending byte enable.
  assign low = mask_q & (~mask_q + 4'd1);

  // Fires one cycle early so err lands exactly WAIT_MAX cycles after tx_dv.
  assign timeout = (WAIT_MAX != 0) && (tmr_q == TMAX - 1'b1);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    dv_d    = 1'b0;
    byte_d  = tx_byte;
    tmr_d   = tmr_q;
    err_d   = err_clr ? 2'b00 : err;
    if (wr_valid & full) err_d[ERR_OVF] = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          word_d  = head.data;
          mask_d  = byte_mask(head.strobe);
          state_d = LOAD;
        end
      end
      LOAD: begin
        dv_d    = 1'b1;
        tmr_d   = '0;
        mask_d  = mask_q & ~low;
        state_d = WAIT;
        unique case (1'b1)
          low[0]:  byte_d = word_q[7:0];
          low[1]:  byte_d = word_q[15:8];
          low[2]:  byte_d = word_q[23:16];
          low[3]:  byte_d = word_q[31:24];
          default: byte_d = word_q[7:0];
        endcase
      end
      WAIT: begin
        if (tmr_q != TMAX) tmr_d = tmr_q + 1'b1;
        if (tx_done) begin
          state_d = (mask_q != 4'd0) ? LOAD : IDLE;
        end else if (timeout) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          mask_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      tx_dv   <= 1'b0;
      tx_byte <= '0;
      tmr_q   <= '0;
      err     <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      tx_dv   <= dv_d;
      tx_byte <= byte_d;
      tmr_q   <= tmr_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_strb_word_serializer.sv
// Directed and randomized bench for strb_word_serializer.
// Expected bytes come from a word-level model; a responder plays uart_tx.
module tb_strb_word_serializer;

  localparam int DEPTH    = 4;
  localparam int WAIT_MAX = 16;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        wr_valid  = 1'b0;
  logic [31:0] wr_data   = '0;
  logic [1:0]  wr_strobe = '0;
  logic        busy;
  logic [2:0]  level;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done   = 1'b0;
  logic [1:0]  err;
  logic        err_clr   = 1'b0;

  strb_word_serializer #(
    .DEPTH   (DEPTH),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_strobe(wr_strobe),
    .busy     (busy),
    .level    (level),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .tx_done  (tx_done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed requests, written only by the monitor.
  int         obs_n = 0;
  logic [7:0] obs_b [512];
  int         obs_c [512];
  int         obs_g [512];
  int         last_done = -100;
  int         pend = -1;
  int         man_ack = 0;

  // Controls written only by the stimulus block.
  int  man_req = 0;
  bit  auto_done = 1'b0;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (tx_dv && obs_n < 512) begin
      obs_b[obs_n] = tx_byte;
      obs_c[obs_n] = cyc;
      obs_g[obs_n] = cyc - last_done;
      obs_n++;
    end
    if (!rst_n) pend = -1;
    if (tx_dv && auto_done && rst_n) pend = int'($urandom_range(0, 3));
    if (man_req != man_ack) begin
      man_ack++;
      tx_done   = 1'b1;
      last_done = cyc;
    end
    if (pend == 0) begin
      tx_done   = 1'b1;
      last_done = cyc;
      pend      = -1;
    end else if (pend > 0) begin
      pend--;
    end
  end

  // Reference model: list of bytes the transmitter must see.
  logic [7:0] exp_b [512];
  bit         exp_f [512];
  int         exp_n = 0;
  int         ro = 0;
  int         re = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic void add_byte(input logic [7:0] b, input bit f);
    if (exp_n < 512) begin
      exp_b[exp_n] = b;
      exp_f[exp_n] = f;
      exp_n++;
    end
  endfunction

  function automatic void add_word(input logic [31:0] d, input logic [1:0] s);
    bit first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (s[i/2]) begin
        add_byte(d[8*i +: 8], first);
        first = 1'b0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s, output int t);
    wr_valid  = 1'b1;
    wr_data   = d;
    wr_strobe = s;
    step();
    t = cyc;
    wr_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic wait_obs(input int n, input string tag);
    int b = 400;
    while (obs_n < n && b > 0) begin
      step();
      b--;
    end
    chk({tag, "_wait"}, 32'(obs_n >= n), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k;
    wait_obs(obs_n + (exp_n - re) - (obs_n - ro), tag);
    repeat (6) step();
    chk({tag, "_count"}, obs_n - ro, exp_n - re);
    k = 0;
    while (ro + k < obs_n && re + k < exp_n) begin
      chk($sformatf("%s_byte%0d", tag, k), obs_b[ro+k], exp_b[re+k]);
      if (!exp_f[re+k])
        chk($sformatf("%s_gap%0d", tag, k), obs_g[ro+k], 32'd2);
      k++;
    end
    ro = obs_n;
    re = exp_n;
  endtask

  initial begin
    int          t0;
    int          b0;
    int          d0;
    int          nw;
    logic [31:0] w;
    logic [31:0] w1;
    logic [1:0]  s;

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_dv", tx_dv, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    auto_done = 1'b1;
    b0 = obs_n;
    push(32'hA1B2C3D4, 2'b11, t0);
    add_word(32'hA1B2C3D4, 2'b11);
    drain("t1");
    chk("t1_latency", obs_c[b0], t0 + 2);
    chk("t1_level", level, 0);

    push(32'h11223344, 2'b10, t0);
    add_word(32'h11223344, 2'b10);
    push(32'h55667788, 2'b00, t0);
    drain("t2");
    chk("t2_err", err, 0);
    chk("t2_level", level, 0);

    auto_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      push(w, 2'b11, t0);
      if (i < 5) add_word(w, 2'b11);
    end
    chk("t3_level", level, 4);
    chk("t3_busy", busy, 1);
    chk("t3_err", err, 2'b10);
    chk("t3_inflight", obs_n - ro, 1);
    man_req++;
    auto_done = 1'b1;
    drain("t3");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_clr", err, 0);
    chk("t3_busy_end", busy, 0);

    auto_done = 1'b0;
    b0 = obs_n;
    w = $urandom;
    push(w, 2'b01, t0);
    add_byte(w[7:0], 1'b1);
    w1 = $urandom;
    push(w1, 2'b10, t0);
    add_word(w1, 2'b10);
    wait_obs(b0 + 1, "t4_dv");
    d0 = obs_c[b0];
    for (int k = 0; k < 40 && cyc < d0 + 15; k++) step();
    chk("t4_err_early", err, 0);
    step();
    chk("t4_err_timeout", err, 2'b01);
    auto_done = 1'b1;
    drain("t4");
    chk("t4_next_start", obs_c[b0+1], d0 + 18);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_clr", err, 0);

    auto_done = 1'b0;
    b0 = obs_n;
    w = $urandom;
    push(w, 2'b01, t0);
    add_word(w, 2'b01);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      push(w, 2'b11, t0);
      add_word(w, 2'b11);
    end
    chk("t5_level_pre", level, 3);
    wait_obs(b0 + 1, "t5_b0");
    man_req++;
    wait_obs(b0 + 2, "t5_b1");
    man_req++;
    step();
    w = $urandom;
    push(w, 2'b11, t0);
    add_word(w, 2'b11);
    chk("t5_level", level, 3);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, 0);
    auto_done = 1'b1;
    drain("t5");

    auto_done = 1'b0;
    b0 = obs_n;
    w = $urandom;
    push(w, 2'b11, t0);
    add_byte(w[7:0], 1'b1);
    wait_obs(b0 + 1, "t6_dv");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_dv", tx_dv, 0);
    chk("t6_byte", tx_byte, 0);
    chk("t6_busy", busy, 0);
    chk("t6_level", level, 0);
    chk("t6_err", err, 0);
    man_req++;
    repeat (5) step();
    chk("t6_late_done", obs_n, b0 + 1);
    auto_done = 1'b1;
    w = $urandom;
    push(w, 2'b11, t0);
    add_word(w, 2'b11);
    drain("t6");
    chk("t6_latency", obs_c[b0+1], t0 + 2);

    for (int b = 0; b < 8; b++) begin
      nw = int'($urandom_range(1, 3));
      for (int j = 0; j < nw; j++) begin
        w = $urandom;
        s = 2'($urandom_range(0, 3));
        push(w, s, t0);
        if (s != 2'b00) add_word(w, s);
      end
      drain($sformatf("rnd%0d", b));
      chk($sformatf("rnd%0d_err", b), err, 0);
      chk($sformatf("rnd%0d_level", b), level, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
